// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the cpu_ctrl sequencer: FSM states, opcode/op
// constants, write-back select codes and the packed control-output word.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_COMPUTE   = 3'd5,
        S_WRITE_REG = 3'd6,
        S_HALT      = 3'd7
    } state_e;

    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;

    typedef struct packed {
        logic       w;
        logic [2:0] rnum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic [1:0] aluop;
        logic [1:0] shift;
    } ctrl_out_t;

    // Output word while idle in WAIT (and while reset is held).
    localparam ctrl_out_t CTRL_IDLE = '{w: 1'b1, default: '0};

endpackage

// File: rtl/cpu_ctrl_if.sv
// Control bus between the sequencer and its environment: start/load/instruction
// in, register-file and ALU control out.
interface cpu_ctrl_if;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w;
    logic [2:0]  rnum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  ALUop;
    logic [1:0]  shift;
    logic [15:0] sximm8;

    modport master (
        output s, load, in,
        input  w, rnum, write, loada, loadb, loadc, loads,
        input  asel, bsel, vsel, ALUop, shift, sximm8
    );

    modport slave (
        input  s, load, in,
        output w, rnum, write, loada, loadb, loadc, loads,
        output asel, bsel, vsel, ALUop, shift, sximm8
    );
endinterface

// File: rtl/instr_dec.sv
// Pure combinational field extraction of the instruction register, including
// sign extension of the 8-bit immediate.
module instr_dec (
    input  logic [15:0] ir,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [1:0]  shift,
    output logic [2:0]  rm,
    output logic [15:0] sximm8
);
    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign shift  = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle instruction sequencer driving register file / ALU enables.
// Optional HALT instruction (opcode 111) enabled by defining HALT_INSN_EN.
module cpu_ctrl
    import ctrl_pkg::*;
(
    input logic       clk,
    input logic       reset,
    cpu_ctrl_if.slave bus
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    ctrl_out_t   out_q, out_d;

    logic [2:0]  opcode, rn, rd, rm;
    logic [1:0]  op, shift_f;
    logic [15:0] sximm8;
    logic        is_cmp, is_mov_reg, is_mov_imm;

    instr_dec u_dec (
        .ir     (ir_q),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .shift  (shift_f),
        .rm     (rm),
        .sximm8 (sximm8)
    );

    assign is_cmp     = (opcode == OPC_ALU) && (op == OP_CMP);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                if (bus.load) ir_d = bus.in;
                if (bus.s) state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_WAIT;
                if (is_mov_imm)
                    state_d = S_WRITE_IMM;
                else if (is_mov_reg)
                    state_d = S_GET_B;
                else if (opcode == OPC_ALU)
                    state_d = (op == OP_MVN) ? S_GET_B : S_GET_A;
`ifdef HALT_INSN_EN
                else if (opcode == OPC_HALT)
                    state_d = S_HALT;
`endif
            end
            S_WRITE_IMM: state_d = S_WAIT;
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_COMPUTE;
            S_COMPUTE:   state_d = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_d = S_WAIT;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_WAIT;
        endcase
    end

    // Outputs are registered: computed for the state being entered. IR only
    // changes on WAIT->DECODE, where every field-dependent output is zero.
    always_comb begin
        out_d = '0;
        case (state_d)
            S_WAIT: out_d = CTRL_IDLE;
            S_WRITE_IMM: begin
                out_d.rnum  = rn;
                out_d.vsel  = VSEL_IMM;
                out_d.write = 1'b1;
                out_d.shift = shift_f;
            end
            S_GET_A: begin
                out_d.rnum  = rn;
                out_d.loada = 1'b1;
                out_d.shift = shift_f;
            end
            S_GET_B: begin
                out_d.rnum  = rm;
                out_d.loadb = 1'b1;
                out_d.shift = shift_f;
            end
            S_COMPUTE: begin
                out_d.loadc = !is_cmp;
                out_d.loads = is_cmp;
                out_d.asel  = is_mov_reg;
                out_d.bsel  = 1'b0;
                out_d.aluop = is_mov_reg ? ALU_ADD : op;
                out_d.shift = shift_f;
            end
            S_WRITE_REG: begin
                out_d.rnum  = rd;
                out_d.vsel  = VSEL_C;
                out_d.write = 1'b1;
                out_d.shift = shift_f;
            end
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
            out_q   <= CTRL_IDLE;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            out_q   <= out_d;
        end
    end

    assign bus.w      = out_q.w;
    assign bus.rnum   = out_q.rnum;
    assign bus.write  = out_q.write;
    assign bus.loada  = out_q.loada;
    assign bus.loadb  = out_q.loadb;
    assign bus.loadc  = out_q.loadc;
    assign bus.loads  = out_q.loads;
    assign bus.asel   = out_q.asel;
    assign bus.bsel   = out_q.bsel;
    assign bus.vsel   = out_q.vsel;
    assign bus.ALUop  = out_q.aluop;
    assign bus.shift  = out_q.shift;
    assign bus.sximm8 = sximm8;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: instruction table with per-cycle expected
// control words fed through a scoreboard, plus reset / reload / halt sequences.
module tb_cpu_ctrl;

    typedef struct packed {
        logic       w;
        logic [2:0] rnum;
        logic [6:0] en;    // write, loada, loadb, loadc, loads, asel, bsel
        logic [1:0] vsel;
        logic [1:0] alu;
        logic [1:0] shift;
    } obs_t;

    typedef struct packed {
        obs_t        o;
        logic [15:0] imm;
    } exp_t;

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] imm;
        logic [2:0]  n;
        obs_t [5:0]  exp;
    } vec_t;

    localparam logic [6:0] EN_WR = 7'b1000000;
    localparam logic [6:0] EN_LA = 7'b0100000;
    localparam logic [6:0] EN_LB = 7'b0010000;
    localparam logic [6:0] EN_LC = 7'b0001000;
    localparam logic [6:0] EN_LS = 7'b0000100;
    localparam logic [6:0] EN_AS = 7'b0000010;

    localparam obs_t IDLE = {1'b1, 16'h0000};
    localparam obs_t Z    = '0;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    vec_t vecs[$];

    cpu_ctrl_if bus ();

    cpu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t o(input logic w, input logic [2:0] rn, input logic [6:0] en,
                               input logic [1:0] vs, input logic [1:0] al, input logic [1:0] sh);
        o = {w, rn, en, vs, al, sh};
    endfunction

    function automatic vec_t mkv(input logic [15:0] ir, input logic [15:0] imm, input int n,
                                 input obs_t e0, input obs_t e1, input obs_t e2,
                                 input obs_t e3, input obs_t e4, input obs_t e5);
        vec_t v;
        v.ir  = ir;
        v.imm = imm;
        v.n   = 3'(n);
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2;
        v.exp[3] = e3; v.exp[4] = e4; v.exp[5] = e5;
        return v;
    endfunction

    function automatic obs_t cur();
        cur = {bus.w, bus.rnum,
               {bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel, bus.bsel},
               bus.vsel, bus.ALUop, bus.shift};
    endfunction

    task automatic check(input string nm, input exp_t e);
        obs_t g;
        g = cur();
        checks++;
        if (g !== e.o) begin
            failures++;
            $display("FAIL %s ctrl: got=%05h want=%05h", nm, g, e.o);
        end
        checks++;
        if (bus.sximm8 !== e.imm) begin
            failures++;
            $display("FAIL %s sximm8: got=%04h want=%04h", nm, bus.sximm8, e.imm);
        end
    endtask

    task automatic push(input obs_t ob, input logic [15:0] imm);
        sb.push_back({ob, imm});
    endtask

    // One comparison per DUT cycle, sampled at the falling edge.
    task automatic drain(input string nm);
        int k = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            check($sformatf("%s_c%0d", nm, k), sb.pop_front());
            k++;
        end
    endtask

    task automatic start(input logic [15:0] ir);
        bus.in = ir; bus.load = 1'b1; bus.s = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0; bus.s = 1'b0; bus.in = 16'($urandom);
    endtask

    initial begin
        reset = 1'b1;
        bus.s = 1'b0; bus.load = 1'b0; bus.in = 16'h0000;

        vecs.push_back(mkv(16'hD105, 16'h0005, 3, Z, o(0,1,EN_WR,2'b10,0,0), IDLE, Z, Z, Z));
        vecs.push_back(mkv(16'hA0C1, 16'hFFC1, 6, Z, o(0,0,EN_LA,0,0,0), o(0,1,EN_LB,0,0,0),
                           o(0,0,EN_LC,0,2'b00,0), o(0,6,EN_WR,0,0,0), IDLE));
        vecs.push_back(mkv(16'hA901, 16'h0001, 5, Z, o(0,1,EN_LA,0,0,0), o(0,1,EN_LB,0,0,0),
                           o(0,0,EN_LS,0,2'b01,0), IDLE, Z));
        vecs.push_back(mkv(16'hB853, 16'h0053, 5, Z, o(0,3,EN_LB,0,0,2'b10),
                           o(0,0,EN_LC,0,2'b11,2'b10), o(0,2,EN_WR,0,0,2'b10), IDLE, Z));
        vecs.push_back(mkv(16'hC0AC, 16'hFFAC, 5, Z, o(0,4,EN_LB,0,0,2'b01),
                           o(0,0,EN_LC|EN_AS,0,2'b00,2'b01), o(0,5,EN_WR,0,0,2'b01), IDLE, Z));
        vecs.push_back(mkv(16'hB3FA, 16'hFFFA, 6, Z, o(0,3,EN_LA,0,0,2'b11), o(0,2,EN_LB,0,0,2'b11),
                           o(0,0,EN_LC,0,2'b10,2'b11), o(0,7,EN_WR,0,0,2'b11), IDLE));
        vecs.push_back(mkv(16'hC8FF, 16'hFFFF, 2, Z, IDLE, Z, Z, Z, Z));
        vecs.push_back(mkv(16'h0080, 16'hFF80, 2, Z, IDLE, Z, Z, Z, Z));
`ifndef HALT_INSN_EN
        vecs.push_back(mkv(16'hE000, 16'h0000, 2, Z, IDLE, Z, Z, Z, Z));
`endif
        vecs.push_back(mkv(16'hD780, 16'hFF80, 3, Z, o(0,7,EN_WR,2'b10,0,0), IDLE, Z, Z, Z));

        // Reset: outputs idle before any clock edge, and s/load ignored while held.
        #2;
        check("reset_async", {IDLE, 16'h0000});
        bus.s = 1'b1; bus.load = 1'b1; bus.in = 16'hD1FF;
        @(negedge clk);
        check("reset_held", {IDLE, 16'h0000});
        reset = 1'b0; bus.s = 1'b0; bus.load = 1'b0;

        foreach (vecs[i]) begin
            for (int k = 0; k < int'(vecs[i].n); k++) push(vecs[i].exp[k], vecs[i].imm);
            start(vecs[i].ir);
            drain($sformatf("vec%0d_%04h", i, vecs[i].ir));
        end

        // Reset asserted mid-ADD while in GET_B.
        push(Z, 16'hFFC1); push(o(0,0,EN_LA,0,0,0), 16'hFFC1); push(o(0,1,EN_LB,0,0,0), 16'hFFC1);
        start(16'hA0C1);
        drain("rst_mid");
        #2 reset = 1'b1;
        #1 check("rst_mid_async", {IDLE, 16'h0000});
        @(negedge clk);
        check("rst_mid_held", {IDLE, 16'h0000});
        reset = 1'b0;
        repeat (4) push(IDLE, 16'h0000);
        drain("rst_mid_after");

        // Load during COMPUTE is ignored; held s re-runs the old IR from WAIT.
        push(Z, 16'hFFC1); push(o(0,0,EN_LA,0,0,0), 16'hFFC1);
        push(o(0,1,EN_LB,0,0,0), 16'hFFC1); push(o(0,0,EN_LC,0,0,0), 16'hFFC1);
        start(16'hA0C1);
        drain("reload_a");
        bus.in = 16'hD2AA; bus.load = 1'b1; bus.s = 1'b1;
        push(o(0,6,EN_WR,0,0,0), 16'hFFC1); push(IDLE, 16'hFFC1); push(Z, 16'hFFC1);
        push(o(0,0,EN_LA,0,0,0), 16'hFFC1); push(o(0,1,EN_LB,0,0,0), 16'hFFC1);
        push(o(0,0,EN_LC,0,0,0), 16'hFFC1); push(o(0,6,EN_WR,0,0,0), 16'hFFC1);
        @(posedge clk); #1 bus.load = 1'b0;
        drain("reload_b");
        bus.s = 1'b0;
        push(IDLE, 16'hFFC1); push(IDLE, 16'hFFC1);
        drain("reload_c");

`ifdef HALT_INSN_EN
        push(Z, 16'h0000);
        repeat (20) push(Z, 16'h0000);
        bus.in = 16'hE000; bus.load = 1'b1; bus.s = 1'b1;
        @(posedge clk); #1 bus.load = 1'b0;
        drain("halt");
        bus.s = 1'b0;
        #2 reset = 1'b1;
        #1 check("halt_rst", {IDLE, 16'h0000});
        @(negedge clk);
        reset = 1'b0;
        push(IDLE, 16'h0000);
        drain("halt_after");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 SHALL provide clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL provide reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL provide s, input, 1 bit: start request, sampled only in WAIT.
REQ-004 SHALL provide load, input, 1 bit: instruction-register load enable.
REQ-005 SHALL provide in, input, 16 bits: instruction word.
REQ-006 SHALL provide w, output, 1 bit: idle/ready indicator.
REQ-007 SHALL provide rnum, output, 3 bits: register-file read/write index.
REQ-008 SHALL provide write, output, 1 bit: register-file write enable.
REQ-009 SHALL provide loada, output, 1 bit: A-register load enable.
REQ-010 SHALL provide loadb, output, 1 bit: B-register load enable.
REQ-011 SHALL provide loadc, output, 1 bit: C-register load enable.
REQ-012 SHALL provide loads, output, 1 bit: status (Z) register load enable.
REQ-013 SHALL provide asel, output, 1 bit: 1 forces ALU Ain to 16'h0000.
REQ-014 SHALL provide bsel, output, 1 bit: 1 selects sximm5 for ALU Bin.
REQ-015 SHALL provide vsel, output, 2 bits: write-back select; 00 = C, 10 = sximm8.
REQ-016 SHALL provide ALUop, output, 2 bits: 00 add, 01 sub, 10 and, 11 not-B.
REQ-017 SHALL provide shift, output, 2 bits: shifter control, copied from IR[4:3].
REQ-018 SHALL provide sximm8, output, 16 bits: IR[7:0] sign-extended.

Function
REQ-019 SHALL latch in into a 16-bit IR on a clk edge when load=1 and state is WAIT; load is ignored in all other states.
REQ-020 SHALL decode IR[15:13] as opcode, IR[12:11] as op, IR[10:8] as Rn, IR[7:5] as Rd, and IR[2:0] as Rm.
REQ-021 SHALL implement states WAIT, DECODE, WRITE_IMM, GET_A, GET_B, COMPUTE, WRITE_REG; all outputs are Moore outputs of state and IR.
REQ-022 SHALL assert w=1 only in WAIT; WAIT with s=1 moves to DECODE on the next edge, otherwise it stays in WAIT.
REQ-023 SHALL follow these paths from DECODE:
  - MOV imm (110/10): WRITE_IMM, then WAIT; total 3 cycles.
  - MOV reg (110/00): GET_B, COMPUTE (asel=1, ALUop=00), WRITE_REG, WAIT.
  - ADD/AND (101/00, 101/10): GET_A, GET_B, COMPUTE, WRITE_REG, WAIT.
  - CMP (101/01): GET_A, GET_B, COMPUTE (loads=1, loadc=0), WAIT.
  - MVN (101/11): GET_B, COMPUTE, WRITE_REG, WAIT.
  - Any other encoding: WAIT, with no enable asserted.
REQ-024 SHALL drive per-state outputs as follows:
  - GET_A: rnum=Rn, loada=1.
  - GET_B: rnum=Rm, loadb=1.
  - COMPUTE: loadc=1 (except CMP), ALUop=op (00 for MOV reg), bsel=0.
  - WRITE_REG: rnum=Rd, vsel=00, write=1.
  - WRITE_IMM: rnum=Rn, vsel=10, write=1.
REQ-025 SHALL hold all enables at 0 and all selects at 0 in WAIT and DECODE.
REQ-026 SHALL, when s and load are both 1 in WAIT, latch the new IR and enter DECODE, so the new instruction executes.
REQ-027 SHALL ignore s outside WAIT; a held-high s starts the next instruction immediately on return to WAIT.

Reset
REQ-028 SHALL, on reset=1, immediately force state to WAIT and IR to 16'h0000, independent of clk.
REQ-029 SHALL, while reset=1, drive w=1 and all other outputs to 0, with sximm8=16'h0000.
REQ-030 SHALL abort any in-flight instruction on reset mid-operation, with no further write pulses.

Configuration
REQ-031 SHALL recognise a HALT instruction when HALT_INSN_EN is defined: opcode 111 moves DECODE to HALT, w=0, all enables 0, and only reset exits HALT.
REQ-032 SHALL, when HALT_INSN_EN is undefined, treat opcode 111 as an undefined encoding (DECODE to WAIT).

Structure
REQ-033 SHALL place the state enum, opcode/op constants and vsel codes in shared package ctrl_pkg.
REQ-034 SHALL isolate IR field extraction and sign extension in combinational sub-module instr_dec.

Verification
REQ-035 SHALL cover MOV imm: load 16'hD105, s pulse -> WRITE_IMM cycle with rnum=1, vsel=10, write=1, sximm8=16'h0005; w=1 three cycles after s.
REQ-036 SHALL cover ADD: load 16'hA0C1 (R6=R0+R1) -> loada with rnum=0, then loadb with rnum=1, then loadc with ALUop=00, then write with rnum=6.
REQ-037 SHALL cover CMP: load 16'hA901 -> COMPUTE with ALUop=01, loads=1, loadc=0, and no write pulse.
REQ-038 SHALL cover reset mid-ADD: reset asserted in GET_B -> w=1 and loadb=0 before the next edge, IR=0.
REQ-039 SHALL cover load during execution: change in and assert load in COMPUTE -> IR unchanged; next instruction executes the old IR only if it is not reloaded in WAIT.
REQ-040 SHALL cover HALT with HALT_INSN_EN defined: load 16'hE000, s -> w stays 0 for 20 cycles, and reset restores w=1.
